// File: rtl/cmd_encoder.sv
// rtl/cmd_encoder.sv - push-button to command-burst encoder (optional auto-repeat: CMD_AUTOREPEAT_EN)
module cmd_encoder #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [7:0]  HOLD_CYCLES     = 8'd4,
    parameter logic [7:0]  GAP_CYCLES      = 8'd4,
    parameter logic [23:0] REPEAT_CYCLES   = 24'd13500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] btn,
    output logic [7:0] cmd,
    output logic       busy,
    output logic [5:0] pend
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 16'd1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 8'd1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 8'd1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t        state, state_d;
    logic [5:0]    s_meta, s_sync, deb, deb_q, press, pick, clr, rep_set, pend_d;
    logic [DW-1:0] deb_cnt [6];
    logic [HW-1:0] hold_cnt, hold_d;
    logic [GW-1:0] gap_cnt, gap_d;
    logic [7:0]    cmd_d;
    logic          busy_d, load;

    function automatic logic [7:0] code_of(input logic [5:0] onehot);
        case (onehot)
            6'b000001: code_of = 8'h77;
            6'b000010: code_of = 8'h65;
            6'b000100: code_of = 8'h70;
            6'b001000: code_of = 8'h64;
            6'b010000: code_of = 8'h62;
            6'b100000: code_of = 8'h73;
            default:   code_of = 8'h00;
        endcase
    endfunction

    // Synchroniser and per-button debounce: a level is accepted only after
    // DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= '0;
            s_sync <= '0;
            deb    <= '0;
            deb_q  <= '0;
            for (int i = 0; i < 6; i++) deb_cnt[i] <= '0;
        end else begin
            s_meta <= btn;
            s_sync <= s_meta;
            deb_q  <= deb;
            for (int i = 0; i < 6; i++) begin
                if (s_sync[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= s_sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign press = deb & ~deb_q;

`ifdef CMD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 24'd1);

    logic [RW-1:0] rep_cnt;
    logic          rep_arm;

    assign rep_arm = (state == IDLE) && (pend == '0) && (|deb);
    assign rep_set = (rep_arm && rep_cnt == REP_LAST) ? (deb & (~deb + 6'd1)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else if (rep_arm && rep_cnt != REP_LAST) begin
            rep_cnt <= rep_cnt + RW'(1);
        end else begin
            rep_cnt <= '0;
        end
    end
`else
    // Without auto-repeat REPEAT_CYCLES has no effect.
    assign rep_set = 6'(REPEAT_CYCLES & 24'd0);
`endif

    // Lowest set bit wins, so wake has the highest priority.
    assign pick = pend & (~pend + 6'd1);
    assign load = (|pend) && ((state == IDLE) || (state == GAP && gap_cnt == GAP_LAST));

    always_comb begin
        state_d = state;
        cmd_d   = cmd;
        busy_d  = busy;
        hold_d  = hold_cnt;
        gap_d   = gap_cnt;
        clr     = '0;
        if (load) begin
            clr     = pick;
            cmd_d   = code_of(pick);
            busy_d  = 1'b1;
            hold_d  = '0;
            gap_d   = '0;
            state_d = SEND;
        end else begin
            case (state)
                IDLE: ;
                SEND: begin
                    if (hold_cnt == HOLD_LAST) begin
                        cmd_d   = 8'h00;
                        hold_d  = '0;
                        gap_d   = '0;
                        state_d = GAP;
                    end else begin
                        hold_d = hold_cnt + HW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_d   = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_cnt + GW'(1);
                    end
                end
                default: begin
                    cmd_d   = 8'h00;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
        // A new press on the same edge as its own clear keeps the bit set.
        pend_d = (pend & ~clr) | press | rep_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd      <= 8'h00;
            busy     <= 1'b0;
            pend     <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_d;
            cmd      <= cmd_d;
            busy     <= busy_d;
            pend     <= pend_d;
            hold_cnt <= hold_d;
            gap_cnt  <= gap_d;
        end
    end

endmodule

// File: tb/tb_cmd_encoder.sv
// tb/tb_cmd_encoder.sv - directed vector bench for cmd_encoder (DEBOUNCE=4, HOLD=3, GAP=2)
module tb_cmd_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] btn;
    logic [7:0] cmd;
    logic       busy;
    logic [5:0] pend;

    always #5 clk = ~clk;

    cmd_encoder #(
        .DEBOUNCE_CYCLES(16'd4),
        .HOLD_CYCLES    (8'd3),
        .GAP_CYCLES     (8'd2),
        .REPEAT_CYCLES  (24'd20)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn),
        .cmd  (cmd),
        .busy (busy),
        .pend (pend)
    );

    typedef struct {
        logic [5:0] btn;
        logic [7:0] cmd;
        logic       busy;
        logic [5:0] pend;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic [5:0] b, input logic [7:0] c,
                                input logic y, input logic [5:0] p);
        vec_t v;
        v.btn  = b;
        v.cmd  = c;
        v.busy = y;
        v.pend = p;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] ecmd,
                         input logic ebusy, input logic [5:0] epend);
        n_vec++;
        if (cmd !== ecmd || busy !== ebusy || pend !== epend) begin
            n_miss++;
            $display("FAIL %s[%0d]: got cmd=%02h busy=%0b pend=%06b, want cmd=%02h busy=%0b pend=%06b",
                     name, idx, cmd, busy, pend, ecmd, ebusy, epend);
        end
    endtask

    // Entry k: btn is driven before edge k; outputs are checked after edge k.
    task automatic run_tbl(input string name);
        for (int k = 0; k < tbl.size(); k++) begin
            btn = tbl[k].btn;
            @(negedge clk);
            check(name, k, tbl[k].cmd, tbl[k].busy, tbl[k].pend);
        end
        tbl.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset with random button activity
        rst_n = 1'b0;
        btn   = 6'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset", i, 8'h00, 1'b0, 6'b000000);
            btn = 6'($urandom);
        end
        btn   = 6'b000000;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle", i, 8'h00, 1'b0, 6'b000000);
        end

        // feed held 50 cycles: one burst from edge 7
        for (int k = 0; k < 60; k++)
            tbl.push_back(mk((k < 50) ? 6'b000010 : 6'b000000,
                             (k >= 7 && k <= 9) ? 8'h65 : 8'h00,
                             (k >= 7 && k <= 11),
                             (k == 6) ? 6'b000010 : 6'b000000));
        run_tbl("feed_hold");

        // play bouncing 3 high / 3 low never passes the debouncer
        for (int k = 0; k < 70; k++)
            tbl.push_back(mk((k < 60 && (k % 6) < 3) ? 6'b000100 : 6'b000000,
                             8'h00, 1'b0, 6'b000000));
        run_tbl("bounce");

        // sleep and wake together: wake first, sleep loaded straight out of GAP
        for (int k = 0; k < 30; k++)
            tbl.push_back(mk((k <= 19) ? 6'b100001 : 6'b000000,
                             (k >= 7 && k <= 9) ? 8'h77 : (k >= 12 && k <= 14) ? 8'h73 : 8'h00,
                             (k >= 7 && k <= 16),
                             (k == 6) ? 6'b100001 : (k >= 7 && k <= 11) ? 6'b100000 : 6'b000000));
        run_tbl("simul");

        // doctor pressed twice while queued behind wake/feed: second press dropped
        for (int k = 0; k < 40; k++) begin
            logic [5:0] b;
            b = 6'b000000;
            if (k <= 20) b[1:0] = 2'b11;
            if ((k >= 1 && k <= 4) || (k >= 9 && k <= 14)) b[3] = 1'b1;
            tbl.push_back(mk(b,
                             (k >= 7 && k <= 9)   ? 8'h77 :
                             (k >= 12 && k <= 14) ? 8'h65 :
                             (k >= 17 && k <= 19) ? 8'h64 : 8'h00,
                             (k >= 7 && k <= 21),
                             (k == 6) ? 6'b000011 :
                             (k >= 7 && k <= 11)  ? 6'b001010 :
                             (k >= 12 && k <= 16) ? 6'b001000 : 6'b000000));
        end
        run_tbl("drop");

        // Reset in the middle of a burst with a bit still pending
        btn = 6'b010100;
        for (int i = 0; i < 9; i++) @(negedge clk);
        check("midsend_pre", 0, 8'h70, 1'b1, 6'b010000);
        rst_n = 1'b0;
        #1;
        check("reset_async", 0, 8'h00, 1'b0, 6'b000000);
        btn = 6'b000000;
        @(negedge clk);
        check("reset_held", 0, 8'h00, 1'b0, 6'b000000);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_reset", i, 8'h00, 1'b0, 6'b000000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
